// File: rtl/spi_slave_port.sv
// SPI responder: oversampled SCLK/CS_N/MOSI, all CPOL/CPHA modes, one-word TX holding buffer.
// Optional feature macro: SPI_SLAVE_UNDERRUN_EN (sticky underrun flag with status_clear).
module spi_slave_port #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clock_polarity,
  input  logic                  clock_phase,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
`ifdef SPI_SLAVE_UNDERRUN_EN
  output logic                  done,
  input  logic                  status_clear,
  output logic                  underrun
`else
  output logic                  done
`endif
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                  r_sclk_d;
  logic                  r_cs_d;
  logic                  r_cpol;
  logic                  r_cpha;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_reload_pend;
  logic                  r_tx_full;
  logic [DATA_WIDTH-1:0] r_tx_buf;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;

  function automatic logic f_tx_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_tx_shift(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                       input logic b);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction

  // Stage 0: synchronizers plus edge-detect flop. Left unreset so a reset while
  // cs_n is held low cannot fabricate a falling edge and restart a frame mid-way.
  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
    r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
    r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
  end

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic w_active, w_lead, w_trail, w_sample, w_shift, w_last;
  logic w_start, w_reload, w_advance, w_load, w_buf_take;
  logic [DATA_WIDTH-1:0] w_load_word;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;

  // Stage 1: edge classification against the mode latched at frame start
  assign w_active  = (r_state == S_ACTIVE);
  assign w_lead    = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail   = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample  = w_active & (r_cpha ? w_trail : w_lead);
  assign w_shift   = w_active & (r_cpha ? w_lead : w_trail);
  assign w_last    = w_sample & (r_bit_cnt == CW'(DATA_WIDTH - 1));
  assign w_start   = ~w_active & w_cs_fall;
  assign w_reload  = ~w_cs_rise & (r_cpha ? w_last : (w_shift & r_reload_pend));
  // Counter at zero means no bit of the current word has been sampled yet,
  // so there is nothing to advance (covers the CPHA=1 first leading edge).
  assign w_advance = ~w_cs_rise & w_shift & ~w_reload & (r_bit_cnt != '0);
  assign w_load    = w_start | w_reload;
  assign w_buf_take  = tx_valid & ~r_tx_full;
  assign w_load_word = r_tx_full ? r_tx_buf : (tx_valid ? tx_data : '0);
  assign w_rx_next   = f_rx_shift(r_rx_shift, w_mosi_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_bit_cnt     <= '0;
      r_reload_pend <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state       <= S_ACTIVE;
            r_cpol        <= clock_polarity;
            r_cpha        <= clock_phase;
            r_bit_cnt     <= '0;
            r_reload_pend <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (w_shift) r_reload_pend <= 1'b0;
          if (w_sample) begin
            if (w_last) begin
              r_rx_data     <= w_rx_next;
              r_rx_valid    <= 1'b1;
              r_bit_cnt     <= '0;
              r_reload_pend <= ~r_cpha;
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end
          if (w_cs_rise) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_reload_pend <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             r_tx_full <= 1'b0;
    else if (w_load)     r_tx_full <= 1'b0;
    else if (w_buf_take) r_tx_full <= 1'b1;
  end

  // Stage 2: datapath registers (buffer, shifters)
  always_ff @(posedge clk) begin
    if (w_buf_take) r_tx_buf <= tx_data;
    if (w_load)         r_tx_shift <= w_load_word;
    else if (w_advance) r_tx_shift <= f_tx_shift(r_tx_shift);
    if (w_sample) r_rx_shift <= w_rx_next;
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic r_underrun;
  always_ff @(posedge clk) begin
    if (rst)                                r_underrun <= 1'b0;
    else if (w_load & ~r_tx_full & ~tx_valid) r_underrun <= 1'b1;
    else if (status_clear)                  r_underrun <= 1'b0;
  end
  assign underrun = r_underrun;
`endif

  assign miso     = w_active & f_tx_bit(r_tx_shift);
  assign miso_oe  = w_active;
  assign busy     = w_active;
  assign tx_ready = ~r_tx_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign done     = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_port.sv
// Scoreboard bench for spi_slave_port: an MSB-first instance plus an LSB-first instance.
module tb_spi_slave_port;
  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cpol, cpha, sclk, cs_n, mosi, tx_valid;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, busy, done;
  logic [7:0] rx_data;
  logic       l_miso, l_miso_oe, l_tx_ready, l_rx_valid, l_busy, l_done;
  logic [7:0] l_rx_data;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic status_clear, underrun, l_underrun;
`endif

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int l_rx_cnt = 0;
  bit mon_main = 1'b1;
  bit mon_lsb = 1'b0;
  logic [7:0] sb_main[$];
  logic [7:0] sb_lsb[$];
  logic [7:0] m_exp, l_exp;

  spi_slave_port #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .clock_polarity(cpol), .clock_phase(cpha),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .done(done)
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .status_clear(status_clear), .underrun(underrun)
`endif
  );

  spi_slave_port #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .clock_polarity(cpol), .clock_phase(cpha),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(l_miso), .miso_oe(l_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(l_tx_ready),
    .rx_data(l_rx_data), .rx_valid(l_rx_valid), .busy(l_busy),
    .done(l_done)
`ifdef SPI_SLAVE_UNDERRUN_EN
    , .status_clear(status_clear), .underrun(l_underrun)
`endif
  );

  always @(negedge clk) begin
    if (mon_main && (rx_valid || done)) begin
      total++;
      if (done !== rx_valid) begin
        bad++;
        $display("FAIL done_align rx_valid=%b done=%b (must match)", rx_valid, done);
      end
      if (rx_valid === 1'b1) begin
        rx_cnt++;
        total++;
        if (sb_main.size() == 0) begin
          bad++;
          $display("FAIL rx_word got=%h expected=none", rx_data);
        end else begin
          m_exp = sb_main.pop_front();
          if (rx_data !== m_exp) begin
            bad++;
            $display("FAIL rx_word got=%h expected=%h", rx_data, m_exp);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_lsb && (l_rx_valid || l_done)) begin
      total++;
      if (l_done !== l_rx_valid) begin
        bad++;
        $display("FAIL lsb_done_align rx_valid=%b done=%b (must match)", l_rx_valid, l_done);
      end
      if (l_rx_valid === 1'b1) begin
        l_rx_cnt++;
        total++;
        if (sb_lsb.size() == 0) begin
          bad++;
          $display("FAIL lsb_rx_word got=%h expected=none", l_rx_data);
        end else begin
          l_exp = sb_lsb.pop_front();
          if (l_rx_data !== l_exp) begin
            bad++;
            $display("FAIL lsb_rx_word got=%h expected=%h", l_rx_data, l_exp);
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b1 && t < 100) begin
      wait_clk(1);
      t++;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_busy_timeout busy=%b expected=1", tag, busy);
    end
  endtask

  // Master model: words packed 8 bits each in mo/mi, word 0 in bits [7:0].
  task automatic spi_xfer(input logic pol, input logic pha, input int nbits,
                          input logic [23:0] mo, input bit lsb, input bit use_l,
                          output logic [23:0] mi);
    logic [7:0] w;
    logic b, c;
    int j, i;
    mi = '0;
    cpol = pol; cpha = pha; sclk = pol; cs_n = 1'b1;
    wait_clk(H);
    cs_n = 1'b0;
    wait_clk(H);
    for (int k = 0; k < nbits; k++) begin
      j = k / 8;
      i = k % 8;
      w = mo[j*8 +: 8];
      b = lsb ? w[i] : w[7-i];
      if (!pha) begin
        mosi = b;
        wait_clk(H);
        sclk = ~pol;
        c = use_l ? l_miso : miso;
        wait_clk(H);
        sclk = pol;
      end else begin
        wait_clk(H);
        sclk = ~pol;
        mosi = b;
        wait_clk(H);
        sclk = pol;
        c = use_l ? l_miso : miso;
      end
      if (lsb) mi[j*8+i] = c;
      else     mi[j*8+7-i] = c;
    end
    wait_clk(H);
    cs_n = 1'b1;
    wait_clk(H);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
`ifdef SPI_SLAVE_UNDERRUN_EN
    status_clear = 1'b0;
`endif
    wait_clk(5);
    total++; if (miso !== 1'b0)     begin bad++; $display("FAIL rst_miso got=%b expected=0", miso); end
    total++; if (miso_oe !== 1'b0)  begin bad++; $display("FAIL rst_miso_oe got=%b expected=0", miso_oe); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b expected=1", tx_ready); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h expected=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b expected=0", rx_valid); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b expected=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done got=%b expected=0", done); end
`ifdef SPI_SLAVE_UNDERRUN_EN
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got=%b expected=0", underrun); end
`endif
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_mode0();
    logic [23:0] mi;
    int c0;
    load_tx(8'hA5);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL m0_tx_ready_loaded got=%b expected=0", tx_ready); end
    sb_main.push_back(8'h3C);
    c0 = rx_cnt;
    fork
      spi_xfer(1'b0, 1'b0, 8, 24'h00003C, 1'b0, 1'b0, mi);
      begin
        wait_busy("m0");
        total++;
        if ({tx_ready, miso_oe, miso} !== 3'b111) begin
          bad++; $display("FAIL m0_start tx_ready,oe,miso got=%b expected=111", {tx_ready, miso_oe, miso});
        end
      end
    join
    total++; if (mi[7:0] !== 8'hA5) begin bad++; $display("FAIL m0_miso_word got=%h expected=a5", mi[7:0]); end
    total++; if (rx_cnt - c0 !== 1) begin bad++; $display("FAIL m0_rx_pulses got=%0d expected=1", rx_cnt - c0); end
    total++;
    if ({busy, miso_oe, miso} !== 3'b000) begin
      bad++; $display("FAIL m0_end busy,oe,miso got=%b expected=000", {busy, miso_oe, miso});
    end
  endtask

  task automatic test_modes();
    logic [23:0] mi;
    int c0;
    for (int m = 1; m < 4; m++) begin
      load_tx(8'h81);
      sb_main.push_back(8'h7E);
      c0 = rx_cnt;
      spi_xfer(m[1], m[0], 8, 24'h00007E, 1'b0, 1'b0, mi);
      total++; if (mi[7:0] !== 8'h81) begin bad++; $display("FAIL mode%0d_miso_word got=%h expected=81", m, mi[7:0]); end
      total++; if (rx_cnt - c0 !== 1) begin bad++; $display("FAIL mode%0d_rx_pulses got=%0d expected=1", m, rx_cnt - c0); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] mi;
    int c0;
`ifdef SPI_SLAVE_UNDERRUN_EN
    status_clear = 1'b1; wait_clk(1); status_clear = 1'b0;
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL b2b_underrun_pre got=%b expected=0", underrun); end
`endif
    load_tx(8'h11);
    sb_main.push_back(8'h5A); sb_main.push_back(8'hC3); sb_main.push_back(8'h96);
    c0 = rx_cnt;
    fork
      spi_xfer(1'b0, 1'b0, 24, 24'h96C35A, 1'b0, 1'b0, mi);
      begin
        wait_busy("b2b");
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_start got=%b expected=1", tx_ready); end
        load_tx(8'h22);
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_after_load got=%b expected=0", tx_ready); end
      end
    join
    total++; if (mi !== 24'h002211) begin bad++; $display("FAIL b2b_miso_words got=%h expected=002211", mi); end
    total++; if (rx_cnt - c0 !== 3) begin bad++; $display("FAIL b2b_rx_pulses got=%0d expected=3", rx_cnt - c0); end
`ifdef SPI_SLAVE_UNDERRUN_EN
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL b2b_underrun_set got=%b expected=1", underrun); end
    status_clear = 1'b1; wait_clk(1); status_clear = 1'b0;
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL b2b_underrun_clear got=%b expected=0", underrun); end
`endif
  endtask

  task automatic test_abort();
    logic [23:0] mi;
    int c0;
    c0 = rx_cnt;
    spi_xfer(1'b0, 1'b0, 5, 24'h0000FF, 1'b0, 1'b0, mi);
    total++; if (rx_cnt - c0 !== 0) begin bad++; $display("FAIL abort_rx_pulses got=%0d expected=0", rx_cnt - c0); end
    total++;
    if ({busy, miso_oe} !== 2'b00) begin
      bad++; $display("FAIL abort_idle busy,oe got=%b expected=00", {busy, miso_oe});
    end
    load_tx(8'h3C);
    sb_main.push_back(8'h99);
    c0 = rx_cnt;
    spi_xfer(1'b0, 1'b0, 8, 24'h000099, 1'b0, 1'b0, mi);
    total++; if (mi[7:0] !== 8'h3C) begin bad++; $display("FAIL abort_next_miso got=%h expected=3c", mi[7:0]); end
    total++; if (rx_cnt - c0 !== 1) begin bad++; $display("FAIL abort_next_rx_pulses got=%0d expected=1", rx_cnt - c0); end
  endtask

  task automatic test_lsb_first();
    logic [23:0] mi;
    int c0;
    mon_main = 1'b0;
    mon_lsb  = 1'b1;
    load_tx(8'h01);
    sb_lsb.push_back(8'hC0);
    c0 = l_rx_cnt;
    spi_xfer(1'b0, 1'b0, 8, 24'h0000C0, 1'b1, 1'b1, mi);
    total++; if (mi[0] !== 1'b1) begin bad++; $display("FAIL lsb_first_bit got=%b expected=1", mi[0]); end
    total++; if (mi[7:0] !== 8'h01) begin bad++; $display("FAIL lsb_miso_word got=%h expected=01", mi[7:0]); end
    total++; if (l_rx_cnt - c0 !== 1) begin bad++; $display("FAIL lsb_rx_pulses got=%0d expected=1", l_rx_cnt - c0); end
    wait_clk(2);
    mon_lsb  = 1'b0;
    mon_main = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [23:0] mi;
    int c0;
    load_tx(8'h42);
    c0 = rx_cnt;
    fork
      spi_xfer(1'b0, 1'b0, 8, 24'h0000E7, 1'b0, 1'b0, mi);
      begin
        wait_clk(60);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mrst_pre_busy got=%b expected=1", busy); end
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mrst_busy got=%b expected=0", busy); end
        total++; if (miso_oe !== 1'b0)  begin bad++; $display("FAIL mrst_miso_oe got=%b expected=0", miso_oe); end
        total++; if (miso !== 1'b0)     begin bad++; $display("FAIL mrst_miso got=%b expected=0", miso); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mrst_tx_ready got=%b expected=1", tx_ready); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mrst_rx_data got=%h expected=00", rx_data); end
        total++; if ({rx_valid, done} !== 2'b00) begin bad++; $display("FAIL mrst_pulses got=%b expected=00", {rx_valid, done}); end
      end
    join
    total++; if (rx_cnt - c0 !== 0) begin bad++; $display("FAIL mrst_rx_pulses got=%0d expected=0", rx_cnt - c0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_end_busy got=%b expected=0", busy); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_abort();
    test_lsb_first();
    test_reset_midframe();
    wait_clk(4);
    total++;
    if (sb_main.size() != 0) begin
      bad++; $display("FAIL sb_leftover got=%0d expected=0", sb_main.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI responder (slave) with a parallel host-side interface.
- Oversamples the external SCLK, CS_N and MOSI in the system clock domain and shifts a DATA_WIDTH-bit word in and out per frame.
- Supports all four CPOL/CPHA modes.
- Sits on the peripheral side of an SPI link, opposite the SPI master controller and its register block.

Parameters:
- DATA_WIDTH, 8, word length in bits (minimum 2).
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (minimum 2).
- MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB shifted first.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- clock_polarity  input  1  CPOL; SCLK idle level.
- clock_phase  input  1  CPHA; 0 = sample on leading edge, 1 = sample on trailing edge.
- sclk  input  1  SPI clock from master, asynchronous.
- cs_n  input  1  chip select, active-low, asynchronous.
- mosi  input  1  serial data in, asynchronous.
- miso  output  1  serial data out.
- miso_oe  output  1  MISO output enable for the pad tristate.
- tx_data  input  DATA_WIDTH  next word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  TX holding buffer empty.
- rx_data  output  DATA_WIDTH  last complete received word.
- rx_valid  output  1  one-cycle pulse; rx_data updated.
- busy  output  1  frame in progress (synchronized cs_n low).
- done  output  1  one-cycle pulse per completed word; same cycle as rx_valid.

Behaviour:
- Reset: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, done=0. Holding buffer empty, state IDLE, bit counter 0. Reset mid-frame aborts the frame; rx_valid does not fire.
- Synchronization:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops, then one extra flop for edge detection.
  - Supported SCLK frequency: f_sclk <= f_clk/(2*(SYNC_STAGES+2)).
- Edge classification:
  - Leading edge = synchronized sclk leaving the CPOL level. Trailing edge = returning to it.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge = the other edge.
- Mode latching: CPOL/CPHA are latched on the cycle cs_n falls and held for the whole frame. Changes while busy are ignored.
- TX holding buffer:
  - tx_valid & tx_ready loads tx_data into the buffer; tx_ready falls the next cycle.
  - tx_valid while tx_ready=0 is ignored and the buffer is not overwritten.
  - The buffer empties (tx_ready=1) when its word moves into the shifter.
- State IDLE:
  - miso_oe=0, miso=0.
  - On synchronized cs_n falling: go to ACTIVE, bit counter=0, busy=1, miso_oe=1.
  - The shifter loads the buffer word, or all-zeros if the buffer is empty (underrun).
  - miso presents the first bit in the same cycle.
- State ACTIVE:
  - Each sample edge: shift in mosi_sync and increment the bit counter.
  - At count DATA_WIDTH: rx_data <= assembled word, pulse rx_valid and done, counter <= 0.
  - Each shift edge advances miso to the next bit, with two exceptions:
    - CPHA=1: the first leading edge of each word does not shift.
    - The word reload point loads the next word (buffer or zeros) instead of shifting.
  - Word reload point: CPHA=0 → trailing edge after the DATA_WIDTH-th sample; CPHA=1 → the DATA_WIDTH-th sample edge itself.
  - Back-to-back words continue while cs_n stays low.
- Frame end / abort:
  - Synchronized cs_n rising: return to IDLE, busy=0, miso_oe=0, miso=0.
  - A partial word (counter != 0) is discarded with no rx_valid.
  - The word in the shifter is lost; the holding buffer is untouched.
- Simultaneous events:
  - A cs_n rise on the same cycle as the DATA_WIDTH-th sample edge still completes the word (rx_valid fires).
  - A buffer load coinciding with a reload point: the reload takes the new tx_data, and tx_ready stays 1.
- Bit order: MSB_FIRST=1 shifts MSB out and in first; MSB_FIRST=0 shifts LSB first. rx_data is always in natural bit order.

Optional Feature:
- Macro: SPI_SLAVE_UNDERRUN_EN.
- Defined:
  - Adds input status_clear (1 bit) and output underrun (1 bit), reset value 0.
  - underrun sets sticky when a word load (frame start or reload point) finds the buffer empty.
  - status_clear=1 clears it; a set event in the same cycle wins.
- Undefined: neither port exists and zeros are sent silently on underrun.

Test Plan:
- Mode 0, DATA_WIDTH=8, tx 0xA5 preloaded, master sends 0x3C → miso stream 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid/done pulse; tx_ready=1 after frame start.
- Modes 1, 2, 3 each with tx 0x81 and master 0x7E → master sees 0x81, rx_data=0x7E; no spurious shift on the first leading edge in CPHA=1.
- Back-to-back: cs_n held low for 3 words, tx 0x11 then 0x22 loaded in time, third word not loaded → master sees 0x11, 0x22, 0x00; three rx_valid pulses; underrun=1 when macro defined, cleared by status_clear.
- Abort: cs_n rises after 5 bits → no rx_valid, busy=0, miso_oe=0. Next full frame receives its word correctly.
- MSB_FIRST=0: tx 0x01 → first miso bit 1; master sends LSB-first 0xC0 → rx_data=0xC0.
- Reset asserted mid-frame (rst=1 for one cycle) → all outputs reach their reset values next cycle; tx_ready=1; no rx_valid.
